// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full adder reused for WIDTH cycles, LSB first,
// with valid/ready handshakes on operands and results.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg, sum_reg;
   logic             carry_reg, cout_reg, ovf_reg;
   logic [CW-1:0]    cnt_reg;
   logic             fa_s, fa_cout;
   logic             last_step, accept;

   full_adder u_fa (
      .a    (a_sh_reg[0]),
      .b    (b_sh_reg[0]),
      .cin  (carry_reg),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign last_step = (cnt_reg == CW'(WIDTH - 1));
   // abort outranks a same-cycle input handshake
   assign accept    = (state_reg == IDLE) && in_valid && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = RUN;
         RUN: begin
            if (abort)          state_next = IDLE;
            else if (last_step) state_next = DONE;
         end
         DONE: if (abort || out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
      busy      = (state_reg != IDLE);
   end

   // Subtraction is A + ~B + 1: invert B at load and seed the carry with 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else if (accept) begin
         a_sh_reg  <= op_a;
         b_sh_reg  <= sub ? ~op_b : op_b;
         carry_reg <= sub;
         cnt_reg   <= '0;
      end else if (state_reg == RUN && !abort) begin
         a_sh_reg  <= a_sh_reg >> 1;
         b_sh_reg  <= b_sh_reg >> 1;
         sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
         carry_reg <= fa_cout;
         if (last_step) begin
            cout_reg <= fa_cout;
            ovf_reg  <= carry_reg ^ fa_cout;
         end else begin
            cnt_reg  <= cnt_reg + 1'b1;
         end
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule
